// File: rtl/dlx_branch_predict_unit.sv
// dlx_branch_predict_unit: ID-stage jump/branch resolver with a direct-mapped BTB feeding IF prediction.
// Define BRU_STATS_EN to build the resolved-branch and mispredict counters; otherwise those ports read 0.
module dlx_branch_predict_unit #(
   parameter int          BTB_DEPTH    = 64,
   parameter logic [1:0]  BR_ALLOC_CTR = 2'b10,
   parameter logic [31:0] LINK_OFFSET  = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] if_pc,
   output logic        if_pred_taken,
   output logic [31:0] if_pred_target,
   input  logic        id_valid,
   input  logic        id_stall,
   input  logic [31:0] id_instruction,
   input  logic [31:0] id_pc_plus_four,
   input  logic [31:0] id_rs1,
   input  logic        id_pred_taken,
   input  logic [31:0] id_pred_target,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        link_we,
   output logic [31:0] link_value,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
);
   localparam int IDX = $clog2(BTB_DEPTH);
   localparam int TW  = 30 - IDX;
   logic [BTB_DEPTH-1:0] valid_q;
   logic [TW-1:0]        tag_q    [BTB_DEPTH];
   logic [31:0]          target_q [BTB_DEPTH];
   logic [1:0]           ctr_q    [BTB_DEPTH];
   logic        redirect_q, redirect_d, link_we_q, link_we_d;
   logic [31:0] redirect_pc_q, redirect_pc_d, link_value_q, link_value_d;
   logic [IDX-1:0] l_idx, u_idx;
   logic           l_hit, u_hit;
   logic [5:0]  op;
   logic        is_j, is_jr, is_br, is_link, taken, resolve, mispredict, btb_we;
   logic [31:0] target, u_pc, wr_target;
   logic [TW-1:0] u_tag;
   logic [1:0]  u_ctr, wr_ctr;
   logic        unused_bits;
   // Lookup reads the array before any same-cycle update lands.
   always_comb begin
      l_idx          = if_pc[IDX+1:2];
      l_hit          = valid_q[l_idx] && tag_q[l_idx] == if_pc[31:IDX+2];
      if_pred_taken  = l_hit && ctr_q[l_idx][1];
      if_pred_target = l_hit ? target_q[l_idx] : 32'd0;
   end
   always_comb begin
      op         = id_instruction[31:26];
      is_j       = op == 6'h02 || op == 6'h03;
      is_jr      = op == 6'h12 || op == 6'h13;
      is_br      = op == 6'h04 || op == 6'h05;
      is_link    = op == 6'h03 || op == 6'h13;
      target     = is_jr ? id_rs1
                 : is_j  ? id_pc_plus_four + {{6{id_instruction[25]}}, id_instruction[25:0]}
                 :         id_pc_plus_four + {{16{id_instruction[15]}}, id_instruction[15:0]};
      taken      = is_j || is_jr || (op == 6'h04 && id_rs1 == 32'd0) || (op == 6'h05 && id_rs1 != 32'd0);
      resolve    = id_valid && !id_stall && !redirect_q;
      mispredict = resolve && (taken != id_pred_taken || (taken && id_pred_target != target));
      u_pc       = id_pc_plus_four - 32'd4;
      u_idx      = u_pc[IDX+1:2];
      u_tag      = u_pc[31:IDX+2];
      u_hit      = valid_q[u_idx] && tag_q[u_idx] == u_tag;
      u_ctr      = ctr_q[u_idx];
      btb_we     = resolve && (is_j || (is_br && (u_hit || taken)));
      wr_ctr     = is_j   ? 2'b11
                 : !u_hit ? BR_ALLOC_CTR
                 : taken  ? (u_ctr == 2'b11 ? 2'b11 : u_ctr + 2'd1)
                 :          (u_ctr == 2'b00 ? 2'b00 : u_ctr - 2'd1);
      wr_target  = (is_j || taken) ? target : target_q[u_idx];
      redirect_d    = mispredict;
      redirect_pc_d = mispredict ? (taken ? target : id_pc_plus_four) : redirect_pc_q;
      link_we_d     = resolve && is_link;
      link_value_d  = link_we_d ? id_pc_plus_four + LINK_OFFSET : link_value_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         redirect_q    <= 1'b0;
         redirect_pc_q <= 32'd0;
         link_we_q     <= 1'b0;
         link_value_q  <= 32'd0;
         valid_q       <= '0;
         for (int i = 0; i < BTB_DEPTH; i++) ctr_q[i] <= 2'b00;
      end else begin
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         link_we_q     <= link_we_d;
         link_value_q  <= link_value_d;
         if (btb_we) begin
            valid_q[u_idx]  <= 1'b1;
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= wr_target;
            ctr_q[u_idx]    <= wr_ctr;
         end
      end
   end
   assign redirect    = redirect_q;
   assign redirect_pc = redirect_pc_q;
   assign link_we     = link_we_q;
   assign link_value  = link_value_q;
   assign unused_bits = ^{u_pc[1:0], if_pc[1:0]};
`ifdef BRU_STATS_EN
   logic [31:0] stat_branches_q, stat_branches_d, stat_mispredicts_q, stat_mispredicts_d;
   logic        is_ctl;
   always_comb begin
      is_ctl             = is_j || is_jr || is_br;
      stat_branches_d    = stat_branches_q + {31'd0, resolve && is_ctl && stat_branches_q != '1};
      stat_mispredicts_d = stat_mispredicts_q + {31'd0, mispredict && stat_mispredicts_q != '1};
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_branches_q    <= 32'd0;
         stat_mispredicts_q <= 32'd0;
      end else begin
         stat_branches_q    <= stat_branches_d;
         stat_mispredicts_q <= stat_mispredicts_d;
      end
   end
   assign stat_branches    = stat_branches_q;
   assign stat_mispredicts = stat_mispredicts_q;
`else
   assign stat_branches    = 32'd0;
   assign stat_mispredicts = 32'd0;
`endif
endmodule

// File: doc/dlx_branch_predict_unit.md
Name: dlx_branch_predict_unit

Overview:
- Parametrised successor to the ID-stage jump/branch resolver.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters; the IF stage uses it for prediction.
- Resolves j/jal/jr/jalr/beqz/bnez in ID and issues a registered one-cycle redirect on mispredict.
- Produces the r31 link write for jal/jalr.

Parameters:
- BTB_DEPTH, 64: number of BTB entries; power of 2, at least 2. IDX = log2(BTB_DEPTH).
- BR_ALLOC_CTR, 2'b10: counter value loaded when a taken conditional branch allocates an entry.
- LINK_OFFSET, 0: byte value added to pc_plus_four to form the link value (0 gives PC+4; 4 gives PC+8 for delay-slot builds).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- if_pc  in  32  fetch PC used for BTB lookup.
- if_pred_taken  out  1  combinational: BTB hit and counter[1]==1.
- if_pred_target  out  32  combinational: target stored in the hit entry; 0 on miss.
- id_valid  in  1  ID holds a real instruction.
- id_stall  in  1  ID is frozen this cycle.
- id_instruction  in  32  instruction in ID.
- id_pc_plus_four  in  32  PC+4 of the ID instruction.
- id_rs1  in  32  forwarded rs1 value.
- id_pred_taken  in  1  prediction carried down from IF.
- id_pred_target  in  32  predicted target carried down from IF.
- redirect  out  1  registered one-cycle pulse: flush and refetch.
- redirect_pc  out  32  registered correct next PC.
- link_we  out  1  registered one-cycle pulse: write r31.
- link_value  out  32  registered: id_pc_plus_four + LINK_OFFSET.
- stat_branches  out  32  resolved control-transfer count (see Optional Feature).
- stat_mispredicts  out  32  mispredict count (see Optional Feature).

Behaviour:
- Decode on opcode [31:26]:
  - 0x02 j, 0x03 jal: target = pc4 + sext(instr[25:0]).
  - 0x12 jr, 0x13 jalr: target = id_rs1.
  - 0x04 beqz (taken iff rs1==0), 0x05 bnez (taken iff rs1!=0): target = pc4 + sext(instr[15:0]).
  - All adds are 32-bit, wrap mod 2^32. Any other opcode is not a control transfer: actual_taken=0.
- Resolve condition: id_valid && !id_stall && !squash, where squash is the current value of the redirect register. The instruction presented in the cycle after a redirect is wrong-path and is ignored.
- Mispredict when (actual_taken != id_pred_taken) or (actual_taken && id_pred_target != target).
- On a resolving mispredict, the next edge sets redirect=1 and redirect_pc = actual_taken ? target : pc4. Otherwise redirect=0; redirect_pc holds its value.
- jal/jalr resolving: link_we=1 for one cycle, link_value = pc4 + LINK_OFFSET. Independent of mispredict.
- BTB entry fields: valid, tag = pc[31:IDX+2], target[31:0], ctr[1:0]. Index = pc[IDX+1:2], where pc = pc4 - 4 on update and if_pc on lookup.
- BTB update, on resolve only:
  - Conditional hit: ctr saturating increment if taken, decrement if not taken (floor 00, ceiling 11); target rewritten when taken.
  - Conditional miss and taken: allocate (valid=1, tag, target, ctr=BR_ALLOC_CTR). Miss and not taken: no allocation.
  - j/jal: allocate or overwrite with ctr=2'b11.
  - jr/jalr: never allocated. A stale hit on that index is left untouched.
- Lookup and update of the same entry in one cycle: lookup returns the pre-update contents (read-before-write).
- id_stall=1: no BTB update; redirect and link_we drive 0 in the next cycle.
- Reset: all valid bits, counters and outputs clear to 0; a pending redirect/link pulse is dropped. The cycle after reset deassertion has no squash.

Optional Feature:
- Macro BRU_STATS_EN.
- Defined:
  - stat_branches increments on every resolving opcode 0x02/0x03/0x04/0x05/0x12/0x13.
  - stat_mispredicts increments on every resolving mispredict.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- After reset, beqz at PC 0x100 (pc4=0x104, imm=0x0010, rs1=0, pred 0) -> next cycle redirect=1, redirect_pc=0x114; entry 0 (0x100>>2 mod 64) valid, ctr=10; if_pc=0x100 then gives pred_taken=1, target 0x114.
- Same beqz resolved 3 more times, rs1=5 each time (pred 1, 0, 0 as supplied) -> ctr walks 10→01→00→00 with no wrap below 00; redirect_pc=0x104 only on the first (pred 1) mispredict.
- jal at pc4=0x204, name=0x3FFFFFC (-4), pred 0 -> redirect_pc=0x200, link_we=1, link_value=0x204 (LINK_OFFSET=0); BTB ctr=11.
- jr, rs1=0x8000, pred_taken=1, pred_target=0x8000 -> no redirect, no BTB write. Next cycle a bnez with a mispredicting prediction is presented in the cycle after a forced redirect -> squashed, no redirect, no update.
- id_stall=1 with a mispredicting bnez, then reset asserted mid-stream -> no redirect during stall; after reset, BTB lookups miss and all outputs are 0.
- With BRU_STATS_EN: 5 branches, 2 mispredicts -> stat_branches=5, stat_mispredicts=2. Without it: both read 0.
